audio_sfx_scheduler: RTL and testbench
======================================

AUDIO_SFX_SCHEDULER -- requirements
Module: audio_sfx_scheduler

Interface
REQ-001 Parameter STEP_CYCLES, default 4194304: clk cycles per sound-effect step.
REQ-002 Parameter GAP_CYCLES, default 1048576: silent clk cycles between back-to-back effects.
REQ-003 clk  in  1  the single system clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 game_active  in  1  high while a run is in progress.
REQ-006 sfx_req  in  3  effect requests, rising-edge sensitive: [0] jump, [1] coin, [2] crash.
REQ-007 music_note  in  8  background note from the music ROM, fullnote encoding, 0 = rest.
REQ-008 note_out  out  8  registered fullnote to the tone generator, 0 = silence.
REQ-009 music_hold  out  1  high freezes the background music address counter.
REQ-010 sfx_ack  out  3  one-hot, one-cycle pulse marking the grant of an effect.
REQ-011 sfx_busy  out  1  high in SFX or GAP.

Function
REQ-012 A rising edge of sfx_req[i] (previous sample 0, current 1) shall set pending[i].
- A grant clears the granted bit.
- If a new edge and a grant hit the same bit in one cycle, the set wins.
REQ-013 Grant priority: crash > coin > jump.
REQ-014 States: IDLE, MUSIC, SFX, GAP.
REQ-015 IDLE: note_out=0, music_hold=1.
- pending[1:0] is cleared every cycle.
- crash pending -> SFX.
- else game_active=1 -> MUSIC.
REQ-016 MUSIC: note_out=music_note, delayed one cycle; music_hold=0.
- any pending -> SFX with the highest-priority grant.
- else game_active=0 -> IDLE.
REQ-017 SFX plays 4 steps of STEP_CYCLES cycles each, from the granted effect's table.
- note_out shows step 0 in the first SFX cycle, the same cycle sfx_ack pulses.
- music_hold=1 throughout.
REQ-018 Effect tables:
- jump 25,29,32,37
- coin 44,49,49,0
- crash 20,17,13,8
REQ-019 After the last step of an effect:
- pending non-empty -> GAP.
- else game_active=1 -> MUSIC.
- else -> IDLE.
REQ-020 GAP: note_out=0 for GAP_CYCLES cycles, then SFX with a new grant.
- If pending has been cleared by then (game_active=0), go to IDLE instead.
REQ-021 game_active falling clears pending[1:0] and aborts a running jump or coin effect.
- Exit goes to IDLE on the next cycle.
- A crash effect is never aborted.
- A crash edge coincident with the fall is still granted.
REQ-022 Step and gap counters use $clog2 of the larger parameter, count down to 0, and reload on state entry.
- They shall not wrap.

Reset
REQ-023 While rst_n=0, outputs shall be:
- note_out=0
- music_hold=1
- sfx_ack=0
- sfx_busy=0
REQ-024 While rst_n=0, internal state shall be:
- state=IDLE
- pending=0
- request history=0
- all counters=0
REQ-025 A reset asserted mid-effect shall silence note_out immediately (asynchronously).

Configuration
REQ-026 Macro SFX_PREEMPT_EN defined: a crash edge during a jump or coin effect aborts that effect.
- The crash starts directly: SFX step 0 on the next cycle, no GAP.
- The aborted effect is dropped, not re-queued.
REQ-027 Macro SFX_PREEMPT_EN undefined: the crash waits in pending until the running effect completes, then follows REQ-019.

Structure
REQ-028 Package audio_pkg shall hold:
- the state enumeration
- the effect-index constants
- the three 4-entry note tables
- the NOTE_REST constant (0)
REQ-029 Sub-module step_timer: loadable down-counter with a done pulse.
- One instance shall time both SFX steps and GAP.
- Everything else stays in audio_sfx_scheduler.

Verification (bench uses STEP_CYCLES=16, GAP_CYCLES=4)
REQ-030 Reset, then game_active=1, music_note=30 -> note_out=30 within 2 cycles, music_hold=0.
REQ-031 Pulse jump while in MUSIC:
- sfx_ack=001.
- note_out = 25,29,32,37 for 16 cycles each.
- Then note_out follows music_note again.
REQ-032 Coin and jump edges in the same cycle:
- coin granted first: 64 cycles.
- 4 cycles of note_out=0.
- then jump plays.
REQ-033 Crash edge at cycle 20 of a coin effect:
- With SFX_PREEMPT_EN: note_out=20 on the next cycle.
- Without it: crash starts after the coin ends plus the 4-cycle gap.
REQ-034 Drop game_active during a jump effect -> note_out=0 and state IDLE on the next cycle.
- A crash edge in that same cycle -> 20,17,13,8, then IDLE.
REQ-035 Assert rst_n=0 mid-effect -> note_out=0 without a clock edge.
- After release: IDLE, pending=0.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared state encoding, effect indices and note tables for audio_sfx_scheduler.
package audio_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUSIC = 2'd1,
      SFX   = 2'd2,
      GAP   = 2'd3
   } state_t;

   // Effect indices double as bit positions in sfx_req, pending and sfx_ack.
   localparam logic [1:0] EFF_JUMP  = 2'd0;
   localparam logic [1:0] EFF_COIN  = 2'd1;
   localparam logic [1:0] EFF_CRASH = 2'd2;

   localparam logic [7:0] NOTE_REST = 8'd0;

   localparam logic [3:0][7:0] JUMP_NOTES  = {8'd37, 8'd32, 8'd29, 8'd25};
   localparam logic [3:0][7:0] COIN_NOTES  = {8'd0,  8'd49, 8'd49, 8'd44};
   localparam logic [3:0][7:0] CRASH_NOTES = {8'd8,  8'd13, 8'd17, 8'd20};

   function automatic logic [2:0] prio_grant(input logic [2:0] pend);
      logic [2:0] g;
      g = 3'b000;
      if (pend[EFF_CRASH])     g[EFF_CRASH] = 1'b1;
      else if (pend[EFF_COIN]) g[EFF_COIN]  = 1'b1;
      else if (pend[EFF_JUMP]) g[EFF_JUMP]  = 1'b1;
      return g;
   endfunction

   function automatic logic [1:0] grant_index(input logic [2:0] grant);
      logic [1:0] idx;
      idx = EFF_JUMP;
      if (grant[EFF_CRASH])     idx = EFF_CRASH;
      else if (grant[EFF_COIN]) idx = EFF_COIN;
      return idx;
   endfunction

   function automatic logic [7:0] effect_note(input logic [1:0] effect,
                                              input logic [1:0] step);
      logic [7:0] n;
      case (effect)
         EFF_JUMP:  n = JUMP_NOTES[step];
         EFF_COIN:  n = COIN_NOTES[step];
         EFF_CRASH: n = CRASH_NOTES[step];
         default:   n = NOTE_REST;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/audio_sfx_scheduler_step_timer.sv
// step_timer: loadable down-counter that stops at zero and pulses done once per load.
module step_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             armed_q, armed_d;

   always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      if (load) begin
         cnt_d   = load_val;
         armed_d = 1'b1;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end else begin
         armed_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

   // armed keeps a counter that idles at zero from reporting done again.
   assign done = armed_q && (cnt_q == '0);

endmodule

// File: rtl/audio_sfx_scheduler.sv
// Mixes background music with prioritised jump/coin/crash sound effects.
// Define SFX_PREEMPT_EN to let a crash edge cut a running jump or coin effect short.
module audio_sfx_scheduler #(
   parameter int unsigned STEP_CYCLES = 4194304,
   parameter int unsigned GAP_CYCLES  = 1048576
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       game_active,
   input  logic [2:0] sfx_req,
   input  logic [7:0] music_note,
   output logic [7:0] note_out,
   output logic       music_hold,
   output logic [2:0] sfx_ack,
   output logic       sfx_busy
);
   import audio_pkg::*;

   localparam int unsigned MAX_CYCLES = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
   localparam int CNT_W = ($clog2(MAX_CYCLES) > 0) ? $clog2(MAX_CYCLES) : 1;
   localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

   state_t     state_q, state_d;
   logic [2:0] pending_q, pending_d;
   logic [2:0] req_prev_q;
   logic [1:0] effect_q, effect_d;
   logic [1:0] step_q, step_d;
   logic [7:0] note_q, note_d;
   logic [2:0] ack_q, ack_d;

   logic [2:0]       edges;
   logic [2:0]       pend_vis;
   logic [2:0]       grant_pend;
   logic [2:0]       grant;
   logic             preempt;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic             tmr_done;

   assign edges = sfx_req & ~req_prev_q;

`ifdef SFX_PREEMPT_EN
   assign preempt = (state_q == SFX) && (effect_q != EFF_CRASH) && game_active
                    && edges[EFF_CRASH];
`else
   assign preempt = 1'b0;
`endif

   // Jump and coin are only eligible while a run is in progress outside IDLE.
   always_comb begin
      pend_vis = pending_q;
      if (!game_active || state_q == IDLE) pend_vis[1:0] = 2'b00;
   end

   // NOTE: every signal this block drives gets a default first, so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      effect_d   = effect_q;
      step_d     = step_q;
      ack_d      = 3'b000;
      grant_pend = 3'b000;
      tmr_load   = 1'b0;
      tmr_val    = STEP_LOAD;

      case (state_q)
         IDLE: begin
            if (pend_vis[EFF_CRASH]) grant_pend = prio_grant(pend_vis);
            else if (game_active)    state_d    = MUSIC;
         end
         MUSIC: begin
            if (|pend_vis)         grant_pend = prio_grant(pend_vis);
            else if (!game_active) state_d    = IDLE;
         end
         SFX: begin
            if (preempt) begin
               state_d = SFX;
            end else if (effect_q != EFF_CRASH && !game_active) begin
               state_d = IDLE;
            end else if (tmr_done) begin
               if (step_q == 2'd3) begin
                  if (|pend_vis) begin
                     state_d  = GAP;
                     tmr_load = 1'b1;
                     tmr_val  = GAP_LOAD;
                  end else if (game_active) begin
                     state_d = MUSIC;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  step_d   = step_q + 2'd1;
                  tmr_load = 1'b1;
               end
            end
         end
         GAP: begin
            if (tmr_done) begin
               if (|pend_vis) grant_pend = prio_grant(pend_vis);
               else           state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // A preempting crash is granted straight from its edge, never from pending.
      grant = preempt ? 3'b100 : grant_pend;
      if (|grant) begin
         state_d  = SFX;
         effect_d = grant_index(grant);
         step_d   = 2'd0;
         ack_d    = grant;
         tmr_load = 1'b1;
         tmr_val  = STEP_LOAD;
      end

      pending_d = (pending_q & ~grant_pend) | (edges & ~(preempt ? 3'b100 : 3'b000));
      if (!game_active || state_q == IDLE) pending_d[1:0] = 2'b00;

      case (state_d)
         MUSIC:   note_d = music_note;
         SFX:     note_d = effect_note(effect_d, step_d);
         default: note_d = NOTE_REST;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pending_q  <= 3'b000;
         req_prev_q <= 3'b000;
         effect_q   <= EFF_JUMP;
         step_q     <= 2'd0;
         note_q     <= NOTE_REST;
         ack_q      <= 3'b000;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         req_prev_q <= sfx_req;
         effect_q   <= effect_d;
         step_q     <= step_d;
         note_q     <= note_d;
         ack_q      <= ack_d;
      end
   end

   step_timer #(
      .CNT_W (CNT_W)
   ) u_step_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   assign note_out   = note_q;
   assign sfx_ack    = ack_q;
   assign music_hold = (state_q != MUSIC);
   assign sfx_busy   = (state_q == SFX) || (state_q == GAP);

endmodule

// File: tb/tb_audio_sfx_scheduler.sv
// Directed bench for audio_sfx_scheduler with STEP_CYCLES=16, GAP_CYCLES=4.
module tb_audio_sfx_scheduler;

   localparam int STEP  = 16;
   localparam int GAPC  = 4;
   localparam int JUMP  = 0;
   localparam int COIN  = 1;
   localparam int CRASH = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       game_active;
   logic [2:0] sfx_req;
   logic [7:0] music_note;
   logic [7:0] note_out;
   logic       music_hold;
   logic [2:0] sfx_ack;
   logic       sfx_busy;

   int tests_run    = 0;
   int tests_failed = 0;

   audio_sfx_scheduler #(
      .STEP_CYCLES (STEP),
      .GAP_CYCLES  (GAPC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .game_active (game_active),
      .sfx_req     (sfx_req),
      .music_note  (music_note),
      .note_out    (note_out),
      .music_hold  (music_hold),
      .sfx_ack     (sfx_ack),
      .sfx_busy    (sfx_busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] tb_note(input int eff, input int s);
      logic [7:0] n;
      n = 8'd0;
      case (eff)
         JUMP:  case (s) 0: n = 8'd25; 1: n = 8'd29; 2: n = 8'd32; default: n = 8'd37; endcase
         COIN:  case (s) 0: n = 8'd44; 1: n = 8'd49; 2: n = 8'd49; default: n = 8'd0;  endcase
         CRASH: case (s) 0: n = 8'd20; 1: n = 8'd17; 2: n = 8'd13; default: n = 8'd8;  endcase
         default: n = 8'd0;
      endcase
      return n;
   endfunction

   // Observes effect cycles first..last-1; cycle 0 is the current sample.
   task automatic play_effect(input int eff, input int first, input int last);
      logic [2:0] ack_exp;
      for (int i = first; i < last; i++) begin
         if (i > 0) tick();
         tests_run++;
         if (note_out !== tb_note(eff, i / STEP) || sfx_busy !== 1'b1 || music_hold !== 1'b1) begin
            tests_failed++;
            $display("FAIL effect%0d cycle %0d: note=%0d busy=%b hold=%b, want note=%0d busy=1 hold=1",
                     eff, i, note_out, sfx_busy, music_hold, tb_note(eff, i / STEP));
         end
         if (i < 2) begin
            ack_exp = 3'b000;
            if (i == 0) ack_exp[eff] = 1'b1;
            tests_run++;
            if (sfx_ack !== ack_exp) begin
               tests_failed++;
               $display("FAIL ack effect%0d cycle %0d: got %b want %b", eff, i, sfx_ack, ack_exp);
            end
         end
      end
   endtask

   task automatic check_music(input string name, input logic [7:0] exp_note);
      tests_run++;
      if (note_out !== exp_note || music_hold !== 1'b0 || sfx_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s: note=%0d hold=%b busy=%b, want note=%0d hold=0 busy=0",
                  name, note_out, music_hold, sfx_busy, exp_note);
      end
   endtask

   task automatic check_idle(input string name);
      tests_run++;
      if (note_out !== 8'd0 || music_hold !== 1'b1 || sfx_busy !== 1'b0 || sfx_ack !== 3'b000) begin
         tests_failed++;
         $display("FAIL %s: note=%0d hold=%b busy=%b ack=%b, want 0/1/0/000",
                  name, note_out, music_hold, sfx_busy, sfx_ack);
      end
   endtask

   task automatic check_gap();
      for (int g = 0; g < GAPC; g++) begin
         if (g > 0) tick();
         tests_run++;
         if (note_out !== 8'd0 || sfx_busy !== 1'b1 || music_hold !== 1'b1 || sfx_ack !== 3'b000) begin
            tests_failed++;
            $display("FAIL gap cycle %0d: note=%0d busy=%b hold=%b ack=%b, want 0/1/1/000",
                     g, note_out, sfx_busy, music_hold, sfx_ack);
         end
      end
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      game_active = 1'b0;
      sfx_req     = 3'b000;
      music_note  = 8'd0;
      #22;
      check_idle("reset_outputs");
      rst_n = 1'b1;
      tick();
      tick();
      check_idle("idle_after_reset");
   endtask

   task automatic test_music();
      game_active = 1'b1;
      music_note  = 8'd30;
      tick();
      tick();
      check_music("music_30", 8'd30);
      music_note = 8'd31;
      check_music("music_registered", 8'd30);
      tick();
      check_music("music_31", 8'd31);
   endtask

   task automatic test_jump();
      sfx_req = 3'b001;
      tick();
      sfx_req = 3'b000;
      check_music("jump_pending", 8'd31);
      tick();
      play_effect(JUMP, 0, 4 * STEP);
      tick();
      check_music("music_after_jump", 8'd31);
   endtask

   task automatic test_back_to_back();
      sfx_req = 3'b011;
      tick();
      sfx_req = 3'b000;
      tick();
      play_effect(COIN, 0, 4 * STEP);
      tick();
      check_gap();
      tick();
      play_effect(JUMP, 0, 4 * STEP);
      tick();
      check_music("music_after_b2b", 8'd31);
   endtask

   task automatic test_crash_during_coin();
      sfx_req = 3'b010;
      tick();
      sfx_req = 3'b000;
      tick();
      play_effect(COIN, 0, 21);
      sfx_req = 3'b100;
`ifdef SFX_PREEMPT_EN
      tick();
      sfx_req = 3'b000;
      play_effect(CRASH, 0, 4 * STEP);
`else
      play_effect(COIN, 21, 4 * STEP);
      sfx_req = 3'b000;
      tick();
      check_gap();
      tick();
      play_effect(CRASH, 0, 4 * STEP);
`endif
      tick();
      check_music("music_after_crash", 8'd31);
   endtask

   task automatic test_abort();
      sfx_req = 3'b001;
      tick();
      sfx_req = 3'b000;
      tick();
      play_effect(JUMP, 0, 6);
      game_active = 1'b0;
      sfx_req     = 3'b100;
      tick();
      check_idle("abort_to_idle");
      sfx_req = 3'b000;
      tick();
      play_effect(CRASH, 0, 4 * STEP);
      tick();
      check_idle("idle_after_crash");
   endtask

   task automatic test_reset_mid();
      game_active = 1'b1;
      tick();
      tick();
      check_music("music_before_reset", 8'd31);
      sfx_req = 3'b010;
      tick();
      sfx_req = 3'b000;
      tick();
      play_effect(COIN, 0, 10);
      sfx_req = 3'b001;
      tick();
      sfx_req = 3'b000;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_idle("async_reset_mid_effect");
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      tick();
      check_music("music_after_reset", 8'd31);
      for (int k = 0; k < 8; k++) begin
         tick();
         tests_run++;
         if (sfx_busy !== 1'b0 || sfx_ack !== 3'b000) begin
            tests_failed++;
            $display("FAIL pending_cleared cycle %0d: busy=%b ack=%b, want 0/000", k, sfx_busy, sfx_ack);
         end
      end
   endtask

   initial begin
      test_reset();
      test_music();
      test_jump();
      test_back_to_back();
      test_crash_during_coin();
      test_abort();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
